// File: rtl/demux_1x4_8bit_loader_pkg.sv
// Shared types and constants for the byte-serial operand loader.
// Optional direct lane addressing is enabled with DEMUX_ADDR_SEL_EN.
package demux_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LANES = 4;
    localparam int unsigned CNT_W = 3;

    typedef logic [1:0]       lane_idx_t;
    typedef logic [CNT_W-1:0] fill_cnt_t;
    typedef logic [LANES-1:0] lane_mask_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Number of loaded lanes in a mask.
    function automatic fill_cnt_t popcount4(input lane_mask_t m);
        fill_cnt_t c;
        c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            c = c + fill_cnt_t'(m[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/demux_1x4_8bit_loader_if.sv
// Byte-in / operand-set-out handshake bundle of the loader.
// The sel lane address exists only when DEMUX_ADDR_SEL_EN is defined.
interface demux_1x4_8bit_loader_if;
    import demux_pkg::*;

    logic [WIDTH-1:0] inp;
    logic             inpValid;
    logic             inpReady;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic             outValid;
    logic             outReady;
    fill_cnt_t        fillCnt;
`ifdef DEMUX_ADDR_SEL_EN
    lane_idx_t        sel;
`endif

    modport master (
`ifdef DEMUX_ADDR_SEL_EN
        output sel,
`endif
        output inp, inpValid, outReady,
        input  inpReady, out0, out1, out2, out3, outValid, fillCnt
    );

    modport slave (
`ifdef DEMUX_ADDR_SEL_EN
        input  sel,
`endif
        input  inp, inpValid, outReady,
        output inpReady, out0, out1, out2, out3, outValid, fillCnt
    );

endinterface

// File: rtl/demux_1x4_8bit_loader_lane.sv
// One operand lane: WIDTH-bit register with write enable, cleared by reset.
module lane_reg_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/demux_1x4_8bit_loader.sv
// Steers a byte stream into four operand lanes (ReA, ImA, ReB, ImB) and
// hands the full set out with valid/ready. DEMUX_ADDR_SEL_EN adds direct lane addressing.
module demux_1x4_8bit_loader
    import demux_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstN,
    input  logic                    clr,
    demux_1x4_8bit_loader_if.slave  bus
);

    state_t           state_q;
    state_t           state_d;
    logic [LANES-1:0] lane_we;
    logic [WIDTH-1:0] lane_q [LANES];

`ifdef DEMUX_ADDR_SEL_EN
    lane_mask_t mask_q;
    lane_mask_t mask_d;

    // Completion is tracked by which lanes have been written at least once.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= FILL;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        lane_we = '0;
        if (clr) begin
            state_d = FILL;
            mask_d  = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (bus.inpValid) begin
                        lane_we[bus.sel] = 1'b1;
                        mask_d           = mask_q | (lane_mask_t'(1) << bus.sel);
                        if (mask_d == '1) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.outReady) begin
                        state_d = FILL;
                        mask_d  = '0;
                    end
                end
            endcase
        end
    end

    assign bus.fillCnt = popcount4(mask_q);
`else
    fill_cnt_t cnt_q;
    fill_cnt_t cnt_d;

    // Lanes are filled strictly in order; the low counter bits address the lane.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_we = '0;
        if (clr) begin
            state_d = FILL;
            cnt_d   = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (bus.inpValid) begin
                        lane_we[cnt_q[1:0]] = 1'b1;
                        cnt_d               = cnt_q + 3'd1;
                        if (cnt_d == fill_cnt_t'(LANES)) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.outReady) begin
                        state_d = FILL;
                        cnt_d   = '0;
                    end
                end
            endcase
        end
    end

    assign bus.fillCnt = cnt_q;
`endif

    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        lane_reg_8bit #(.WIDTH(WIDTH)) u_lane (
            .clk  (clk),
            .rstN (rstN),
            .we   (lane_we[g]),
            .d    (bus.inp),
            .q    (lane_q[g])
        );
    end

    // Handshake flags are pure decodes of the state register.
    assign bus.inpReady = (state_q == FILL);
    assign bus.outValid = (state_q == HOLD);
    assign bus.out0     = lane_q[0];
    assign bus.out1     = lane_q[1];
    assign bus.out2     = lane_q[2];
    assign bus.out3     = lane_q[3];

endmodule

// File: doc/demux_1x4_8bit_loader.md
Name: demux_1x4_8bit_loader

Overview:
- Byte-serial operand loader that feeds the complex multiplier datapath.
- Takes one 8-bit input stream and steers consecutive bytes into four registered lanes: out0=Re(A), out1=Im(A), out2=Re(B), out3=Im(B).
- Presents the full operand set with a valid/ready handshake.
- Functionally it is the reverse of the 4:1 8-bit operand multiplexer: one source distributed to four sinks, with storage.

Parameters:
- WIDTH, 8, bit width of the input byte and of each lane register
- LANES, 4, number of output lanes; fixed at 4, and the lane index is 2 bits

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rstN  input  1  asynchronous, active-low reset
- clr  input  1  synchronous abort of the current fill
- inp  input  WIDTH  byte to be stored
- inpValid  input  1  inp is valid this cycle
- inpReady  output  1  loader accepts inp this cycle
- out0..out3  output  WIDTH each  registered lane contents
- outValid  output  1  all four lanes loaded and stable
- outReady  input  1  consumer takes the operand set
- fillCnt  output  3  number of lanes loaded in the current set, 0..4

Behaviour:
- Reset (rstN=0, asynchronous):
  - out0..out3=0, outValid=0, fillCnt=0, state=FILL.
  - inpReady=1 after release.
  - Reset mid-fill discards partial data.
- States:
  - FILL: inpReady=1, outValid=0.
  - HOLD: inpReady=0, outValid=1.
- Input transfer: occurs when inpValid && inpReady at the clock edge.
  - The byte is written to lane fillCnt[1:0] and fillCnt increments.
  - Other lanes are unchanged.
- FILL->HOLD: on the transfer that makes fillCnt=4.
  - outValid rises the cycle after the 4th byte is accepted (1-cycle latency).
  - The 4th byte is visible on out3 in that same cycle.
- HOLD->FILL: on outValid && outReady.
  - fillCnt clears to 0 and outValid drops the next cycle.
  - inpReady rises the next cycle.
  - No byte is accepted in the handoff cycle.
- Lane registers keep their values after handoff until overwritten; consumers must qualify with outValid.
- outValid and out0..out3 are stable throughout HOLD, regardless of inpValid.
- inpValid with inpReady=0 has no effect; the producer holds data until accepted.
- clr:
  - In FILL: fillCnt=0 next cycle, lanes not cleared, a coincident byte is dropped.
  - In HOLD: returns to FILL with outValid=0, and the set is discarded.
  - clr has priority over both the input and output handshakes.
- fillCnt never exceeds 4 and wraps only through handoff or clr.
- All outputs are driven from registers or state decode; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: DEMUX_ADDR_SEL_EN.
- Defined:
  - Adds input sel[1:0] (direct lane address, analogous to the mux select).
  - Each accepted byte goes to lane sel.
  - A 4-bit loaded mask replaces the counter for completion: FILL->HOLD when mask==4'b1111.
  - Rewriting an already-loaded lane overwrites its data and leaves the mask unchanged.
  - fillCnt reports the popcount of the mask.
  - The mask clears on handoff, clr, and reset.
- Undefined:
  - No sel port.
  - Strict sequential lane order 0,1,2,3 as described above.

Decomposition:
- Package demux_pkg:
  - LANES=4 and WIDTH=8 constants.
  - lane_idx_t, a 2-bit typedef.
  - state_t enum {FILL, HOLD}.
  - fill_cnt_t, a 3-bit typedef.
- Sub-module lane_reg_8bit:
  - WIDTH-bit register with async active-low reset to 0 and a write enable.
  - Instantiated four times; the top-level module holds the FSM, counter/mask, and write-enable decode.

Test Plan:
- Reset then feed inp=0x11,0x22,0x33,0x44 on consecutive cycles with inpValid=1 and outReady=0 -> outValid=1 on cycle 5, out0..3=11/22/33/44, fillCnt=4, inpReady=0.
- In HOLD, keep inpValid=1 with inp=0xAA for 3 cycles, then pulse outReady -> outs unchanged during HOLD; next cycle outValid=0 and fillCnt=0; 0xAA is then accepted into out0.
- Feed 2 bytes (0x01,0x02), assert clr with inpValid=1 and inp=0x03, then feed 0x05,0x06,0x07,0x08 -> 0x03 dropped, final out0..3=05/06/07/08.
- Feed 3 bytes, drive rstN low for one cycle mid-clock -> outputs 0 immediately (asynchronous), fillCnt=0; the next 4 bytes produce a clean set.
- Insert inpValid gaps (pattern 1,0,0,1,1,0,1) -> exactly 4 transfers and outValid only after the 4th; outReady held at 1 yields back-to-back sets with one dead cycle between them.
- With DEMUX_ADDR_SEL_EN, sel=3,1,1,0,2 with data 0xD3,0xB1,0xC1,0xA0,0xE2 -> outValid after the 5th transfer, out0..3=A0/C1/E2/D3, fillCnt sequence 1,2,2,3,4.
